// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the digit-serial add/subtract/compare unit.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the step counter; never narrower than one bit.
  function automatic int step_cnt_width(input int n_steps);
    int w;
    w = $clog2(n_steps);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

  // Compare flags {AequalB, AgreaterB, BgreaterA} derived from the
  // subtraction result; all zero for an addition.
  function automatic logic [2:0] cmp_flags(input logic m, input logic sgn,
                                           input logic c, input logic ovf,
                                           input logic msb, input logic z);
    logic lt;
    if (!m) begin
      return 3'b000;
    end else if (sgn) begin
      lt = msb ^ ovf;
      return {z, ~z & ~lt, lt};
    end else begin
      return {z, c & ~z, ~c};
    end
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry into
// the slice's top bit so the caller can form signed overflow.
module addsub_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic carry_s;

  // Ripple through the slice; c_msb_in ends holding the carry into bit DIGIT-1.
  always_comb begin
    carry_s  = cin;
    c_msb_in = cin;
    s        = {DIGIT{1'b0}};
    for (int i = 0; i < DIGIT; i++) begin
      c_msb_in = carry_s;
      s[i]     = a[i] ^ b[i] ^ carry_s;
      carry_s  = (a[i] & b[i]) | (carry_s & (a[i] ^ b[i]));
    end
    cout = carry_s;
  end

endmodule

// File: rtl/serial_addsub_cmp.sv
// Digit-serial add/subtract with magnitude-compare flags. Operands are
// shifted right DIGIT bits per RUN cycle; result digits enter from the top,
// so after N_STEPS cycles the result register holds the full sum.
module serial_addsub_cmp
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             inp_clk,
  input  logic             inp_rst_n,
  input  logic             inp_start,
  input  logic [WIDTH-1:0] inp_A,
  input  logic [WIDTH-1:0] inp_B,
  input  logic             inp_M,
  input  logic             inp_signed,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_S,
  output logic             out_C,
  output logic             out_overflow,
  output logic             out_AequalB,
  output logic             out_AgreaterB,
  output logic             out_BgreaterA
);

  localparam int N_STEPS = WIDTH / DIGIT;
  localparam int SW      = step_cnt_width(N_STEPS);

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic             m_r;
  logic             sgn_r;
  logic [SW-1:0]    step_r;

  logic [DIGIT-1:0] dig_s;
  logic             cout_s;
  logic             cmsb_s;
  logic [WIDTH-1:0] res_next_s;
  logic             last_s;
  logic             ovf_s;
  logic             z_s;
  logic [2:0]       flags_s;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a        (a_r[DIGIT-1:0]),
    .b        (b_r[DIGIT-1:0]),
    .cin      (carry_r),
    .s        (dig_s),
    .cout     (cout_s),
    .c_msb_in (cmsb_s)
  );

  // Next result value and final-step flags; only meaningful on the last step.
  always_comb begin
    res_next_s = (res_r >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
    last_s     = (step_r == SW'(N_STEPS - 1));
    ovf_s      = cout_s ^ cmsb_s;
    z_s        = (res_next_s == {WIDTH{1'b0}});
    flags_s    = cmp_flags(m_r, sgn_r, cout_s, ovf_s, res_next_s[WIDTH-1], z_s);
  end

  // Control FSM, operand shifting and registered outputs.
  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      state_r       <= IDLE;
      a_r           <= {WIDTH{1'b0}};
      b_r           <= {WIDTH{1'b0}};
      res_r         <= {WIDTH{1'b0}};
      carry_r       <= 1'b0;
      m_r           <= 1'b0;
      sgn_r         <= 1'b0;
      step_r        <= {SW{1'b0}};
      out_busy      <= 1'b0;
      out_done      <= 1'b0;
      out_S         <= {WIDTH{1'b0}};
      out_C         <= 1'b0;
      out_overflow  <= 1'b0;
      out_AequalB   <= 1'b0;
      out_AgreaterB <= 1'b0;
      out_BgreaterA <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          out_done <= 1'b0;
          if (inp_start) begin
            a_r      <= inp_A;
            b_r      <= inp_B ^ {WIDTH{inp_M}};
            m_r      <= inp_M;
            sgn_r    <= inp_signed;
            carry_r  <= inp_M;
            step_r   <= {SW{1'b0}};
            res_r    <= {WIDTH{1'b0}};
            out_busy <= 1'b1;
            state_r  <= RUN;
          end else begin
            out_busy <= 1'b0;
          end
        end
        RUN: begin
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          carry_r <= cout_s;
          res_r   <= res_next_s;
          step_r  <= step_r + SW'(1);
          if (last_s) begin
            out_busy      <= 1'b0;
            out_done      <= 1'b1;
            out_S         <= res_next_s;
            out_C         <= cout_s;
            out_overflow  <= ovf_s;
            out_AequalB   <= flags_s[2];
            out_AgreaterB <= flags_s[1];
            out_BgreaterA <= flags_s[0];
            state_r       <= DONE;
          end else begin
            out_busy <= 1'b1;
          end
        end
        DONE: begin
          out_done <= 1'b0;
          out_busy <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          out_done <= 1'b0;
          out_busy <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_cmp.sv
// Directed bench for serial_addsub_cmp: a WIDTH=4/DIGIT=1 instance and a
// WIDTH=8/DIGIT=2 instance, with a scoreboard of expected results.
module tb_serial_addsub_cmp;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [7:0] s;
    logic       c;
    logic       ovf;
    logic       eq;
    logic       agt;
    logic       bgt;
  } obs_t;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       ovf;
    logic       eq;
    logic       agt;
    logic       bgt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start4, m4, sg4;
  logic [3:0] a4, b4;
  logic       busy4, done4, c4, ovf4, eq4, agt4, bgt4;
  logic [3:0] s4;
  logic       start8, m8, sg8;
  logic [7:0] a8, b8;
  logic       busy8, done8, c8, ovf8, eq8, agt8, bgt8;
  logic [7:0] s8;

  serial_addsub_cmp #(.WIDTH(4), .DIGIT(1)) u4 (
    .inp_clk(clk), .inp_rst_n(rst_n), .inp_start(start4), .inp_A(a4), .inp_B(b4),
    .inp_M(m4), .inp_signed(sg4), .out_busy(busy4), .out_done(done4), .out_S(s4),
    .out_C(c4), .out_overflow(ovf4), .out_AequalB(eq4), .out_AgreaterB(agt4),
    .out_BgreaterA(bgt4)
  );

  serial_addsub_cmp #(.WIDTH(8), .DIGIT(2)) u8 (
    .inp_clk(clk), .inp_rst_n(rst_n), .inp_start(start8), .inp_A(a8), .inp_B(b8),
    .inp_M(m8), .inp_signed(sg8), .out_busy(busy8), .out_done(done8), .out_S(s8),
    .out_C(c8), .out_overflow(ovf8), .out_AequalB(eq8), .out_AgreaterB(agt8),
    .out_BgreaterA(bgt8)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic obs_t get(input int d);
    obs_t o;
    if (d == 4) begin
      o = {busy4, done4, {4'h0, s4}, c4, ovf4, eq4, agt4, bgt4};
    end else begin
      o = {busy8, done8, s8, c8, ovf8, eq8, agt8, bgt8};
    end
    return o;
  endfunction

  // Reference: plain integer arithmetic, flags from a direct compare of A and B.
  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                 input logic m, input logic sg);
    exp_t e;
    int mask, ai, bi, bb, sum, sa, sb, ss, as_v, bs_v;
    mask = (1 << w) - 1;
    ai   = int'(a) & mask;
    bi   = int'(b) & mask;
    bb   = m ? (bi ^ mask) : bi;
    sum  = ai + bb + int'(m);
    sa   = (ai >> (w - 1)) & 1;
    sb   = (bb >> (w - 1)) & 1;
    ss   = (sum >> (w - 1)) & 1;
    e.s   = 8'(sum & mask);
    e.c   = 1'(((sum >> w) & 1) == 1);
    e.ovf = 1'((sa == sb) && (ss != sa));
    as_v = (((ai >> (w - 1)) & 1) == 1) ? ai - (1 << w) : ai;
    bs_v = (((bi >> (w - 1)) & 1) == 1) ? bi - (1 << w) : bi;
    if (!m) begin
      e.eq = 1'b0; e.agt = 1'b0; e.bgt = 1'b0;
    end else if (sg) begin
      e.eq = 1'(as_v == bs_v); e.agt = 1'(as_v > bs_v); e.bgt = 1'(as_v < bs_v);
    end else begin
      e.eq = 1'(ai == bi); e.agt = 1'(ai > bi); e.bgt = 1'(ai < bi);
    end
    return e;
  endfunction

  // Pulse start for one edge; returns at the negedge of the first RUN cycle.
  task automatic start_op(input int d, input logic [7:0] a, input logic [7:0] b,
                          input logic m, input logic sg, input bit push);
    @(negedge clk);
    if (d == 4) begin
      a4 = a[3:0]; b4 = b[3:0]; m4 = m; sg4 = sg; start4 = 1'b1;
    end else begin
      a8 = a; b8 = b; m8 = m; sg8 = sg; start8 = 1'b1;
    end
    if (push) sb_q.push_back(model(d, a, b, m, sg));
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  // Check busy over the RUN cycles, then the done cycle and the hold after it.
  task automatic finish_op(input int d, input string name, input bit inject);
    obs_t o;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      o = get(d);
      chk({name, "_busy_run"}, 32'(o.busy), 32'd1);
      chk({name, "_done_run"}, 32'(o.done), 32'd0);
      if (inject && i == 1) begin
        a8 = 8'h01; b8 = 8'h00; m8 = 1'b0; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
    end
    o = get(d);
    chk({name, "_busy_done"}, 32'(o.busy), 32'd0);
    chk({name, "_done"}, 32'(o.done), 32'd1);
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_S"}, 32'(o.s), 32'(e.s));
      chk({name, "_C"}, 32'(o.c), 32'(e.c));
      chk({name, "_ovf"}, 32'(o.ovf), 32'(e.ovf));
      chk({name, "_flags"}, 32'({o.eq, o.agt, o.bgt}), 32'({e.eq, e.agt, e.bgt}));
      @(negedge clk);
      o = get(d);
      chk({name, "_done_pulse"}, 32'(o.done), 32'd0);
      chk({name, "_busy_idle"}, 32'(o.busy), 32'd0);
      chk({name, "_S_hold"}, 32'(o.s), 32'(e.s));
    end
  endtask

  initial begin
    obs_t o;
    rst_n = 1'b0;
    start4 = 1'b0; m4 = 1'b0; sg4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    start8 = 1'b0; m8 = 1'b0; sg8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    #12;
    chk("reset_u4", 32'(get(4)), 32'd0);
    chk("reset_u8", 32'(get(8)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsigned subtract, A > B.
    start_op(4, 8'h0C, 8'h0B, 1'b1, 1'b0, 1'b1);
    finish_op(4, "t1", 1'b0);
    // Signed overflow case, both interpretations.
    start_op(4, 8'h05, 8'h09, 1'b1, 1'b1, 1'b1);
    finish_op(4, "t2s", 1'b0);
    start_op(4, 8'h05, 8'h09, 1'b1, 1'b0, 1'b1);
    finish_op(4, "t2u", 1'b0);
    // Equal operands.
    start_op(4, 8'h0A, 8'h0A, 1'b1, 1'b0, 1'b1);
    finish_op(4, "t3", 1'b0);
    // Add with carry out; a start mid-RUN must be ignored.
    start_op(8, 8'hF0, 8'h20, 1'b0, 1'b0, 1'b1);
    finish_op(8, "t4", 1'b1);
    // Signed compare, negative A less than positive B, on the 8-bit unit.
    start_op(8, 8'h80, 8'h7F, 1'b1, 1'b1, 1'b1);
    finish_op(8, "t6", 1'b0);

    // Abort mid-RUN with an asynchronous reset.
    start_op(8, 8'hAA, 8'h55, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5_busy_before_rst", 32'(busy8), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_u8", 32'(get(8)), 32'd0);
    chk("t5_rst_u4", 32'(get(4)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      o = get(8);
      chk("t5_no_done", 32'({o.busy, o.done}), 32'd0);
    end
    start_op(8, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b1);
    finish_op(8, "t5", 1'b0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
